// File: rtl/uart_txd_if.sv
// Host-side handshake bundle for the 8N1 serial transmitter.
// The host drives the request and byte; the transmitter drives the line and status.
`timescale 1ns/1ps
interface uart_txd_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_start, output tx_data,
                  input  txd, input tx_busy, input tx_done);
  modport slave  (input  tx_start, input tx_data,
                  output txd, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_txd.sv
// 8N1 RS-232 transmitter: start bit, eight data bits LSB first, STOP_BITS stop bits.
// Bit period is BAUD_DIV+1 clocks; all outputs come straight from flops.
`timescale 1ns/1ps
module uart_txd #(
  parameter int BAUD_DIV  = 5624,
  parameter int STOP_BITS = 1
) (
  input logic        clk,
  input logic        reset,
  uart_txd_if.slave  tx_if
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [19:0] BAUD_LAST = 20'(BAUD_DIV);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  logic [1:0]  state_q,    state_d;
  logic [19:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shift_q,    shift_d;
  logic        txd_q,      txd_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;

  logic        baud_end;
  logic [2:0]  next_idx;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    baud_end   = (baud_cnt_q == BAUD_LAST);
    next_idx   = bit_idx_q + 3'd1;

    if (state_q != ST_IDLE) begin
      baud_cnt_d = baud_end ? 20'd0 : baud_cnt_q + 20'd1;
    end

    // Each state decides the next line level one edge ahead so txd is a pure flop.
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = 20'd0;
        txd_d      = 1'b1;
        if (tx_if.tx_start) begin
          shift_d    = tx_if.tx_data;
          state_d    = ST_START;
          busy_d     = 1'b1;
          txd_d      = 1'b0;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
            txd_d      = 1'b1;
          end else begin
            bit_idx_d = next_idx;
            txd_d     = shift_q[next_idx];
          end
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 20'd0;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_if.txd     = txd_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;

endmodule

// File: tb/tb_uart_txd.sv
// Bench for uart_txd: a fast instance (10 clocks/bit) and a real-rate two-stop-bit instance,
// both compared every cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_uart_txd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  uart_txd_if if1 ();
  uart_txd_if if2 ();

  uart_txd #(.BAUD_DIV(9), .STOP_BITS(1)) dut (
    .clk   (clk),
    .reset (rst_n),
    .tx_if (if1)
  );

  uart_txd #(.BAUD_DIV(5624), .STOP_BITS(2)) dut_long (
    .clk   (clk),
    .reset (rst_n),
    .tx_if (if2)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Reference model: a frame is just "clocks since accept"; the line level follows from arithmetic.
  bit         m_busy [2];
  int         m_pos  [2];
  logic [7:0] m_byte [2];
  bit         m_done [2];
  int         bd     [2] = '{9, 5624};
  int         sb     [2] = '{1, 2};

  function automatic int frameLen(int u);
    return (9 + sb[u]) * (bd[u] + 1);
  endfunction

  function automatic logic frameBit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic logic expTxd(int u);
    if (!m_busy[u]) return 1'b1;
    return frameBit(m_byte[u], m_pos[u] / (bd[u] + 1));
  endfunction

  task automatic modelStep(int u, logic rst, logic start, logic [7:0] data);
    m_done[u] = 1'b0;
    if (!rst) begin
      m_busy[u] = 1'b0;
    end else if (m_busy[u]) begin
      m_pos[u]++;
      if (m_pos[u] == frameLen(u)) begin
        m_busy[u] = 1'b0;
        m_done[u] = 1'b1;
      end
    end else if (start) begin
      m_busy[u] = 1'b1;
      m_pos[u]  = 0;
      m_byte[u] = data;
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep(0, rst_n, if1.tx_start, if1.tx_data);
    modelStep(1, rst_n, if2.tx_start, if2.tx_data);
    #1;
    checkOutput("txd",       32'(if1.txd),     32'(expTxd(0)));
    checkOutput("busy",      32'(if1.tx_busy), 32'(m_busy[0]));
    checkOutput("done",      32'(if1.tx_done), 32'(m_done[0]));
    checkOutput("long_txd",  32'(if2.txd),     32'(expTxd(1)));
    checkOutput("long_busy", 32'(if2.tx_busy), 32'(m_busy[1]));
    checkOutput("long_done", 32'(if2.tx_done), 32'(m_done[1]));
    if (if1.tx_done === 1'b1) done_seen++;
  endtask

  task automatic idleCycles(int n);
    repeat (n) stepCycle();
  endtask

  task automatic applyStimulus(logic start, logic [7:0] data);
    if1.tx_start = start;
    if1.tx_data  = data;
    stepCycle();
    if1.tx_start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         d0;
    int         guard;
    int         mode;
    int         busy_cnt;
    int         edges;
    int         idx;
    logic       prev_txd;
    logic [9:0] pat;

    rst_n        = 1'b0;
    if1.tx_start = 1'b1;
    if1.tx_data  = 8'hC3;
    if2.tx_start = 1'b0;
    if2.tx_data  = 8'h00;

    // Held reset with a pending request, then release with no request.
    repeat (3) begin
      stepCycle();
      checkOutput("rst_txd",  32'(if1.txd),     32'd1);
      checkOutput("rst_busy", 32'(if1.tx_busy), 32'd0);
    end
    rst_n        = 1'b1;
    if1.tx_start = 1'b0;
    idleCycles(20);
    checkOutput("post_rst_idle", 32'(if1.tx_busy), 32'd0);

    // Single 0xA3 frame, then back-to-back 0x55 in the done cycle.
    d0 = done_seen;
    applyStimulus(1'b1, 8'hA3);
    checkOutput("a3_start_bit", 32'(if1.txd), 32'd0);
    idleCycles(99);
    checkOutput("a3_busy_last", 32'(if1.tx_busy), 32'd1);
    idleCycles(1);
    checkOutput("a3_done",       32'(if1.tx_done), 32'd1);
    checkOutput("a3_busy_clear", 32'(if1.tx_busy), 32'd0);
    checkOutput("a3_done_count", 32'(done_seen - d0), 32'd1);

    applyStimulus(1'b1, 8'h55);
    checkOutput("b2b_start", 32'(if1.txd), 32'd0);
    pat = 10'b1010101010;
    for (int k = 0; k < 10; k++) begin
      idleCycles(k == 0 ? 5 : 10);
      checkOutput("b2b_bit", 32'(if1.txd), 32'(pat[k]));
    end
    idleCycles(10);

    // Requests while busy are dropped.
    d0 = done_seen;
    applyStimulus(1'b1, 8'h00);
    idleCycles(29);
    applyStimulus(1'b1, 8'hFF);
    idleCycles(69);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("busy_req_done", 32'(if1.tx_done), 32'd1);
    idleCycles(5);
    checkOutput("busy_req_idle",  32'(if1.tx_busy), 32'd0);
    checkOutput("busy_req_count", 32'(done_seen - d0), 32'd1);

    // Reset during data bit 4.
    applyStimulus(1'b1, 8'h5A);
    idleCycles(54);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("midrst_txd",  32'(if1.txd),     32'd1);
    checkOutput("midrst_busy", 32'(if1.tx_busy), 32'd0);
    rst_n = 1'b1;
    d0 = done_seen;
    idleCycles(110);
    checkOutput("midrst_no_done", 32'(done_seen - d0), 32'd0);

    // Randomized frames with stray requests, resets and held requests.
    for (int i = 0; i < 12; i++) begin
      idleCycles($urandom_range(0, 3));
      mode = $urandom_range(0, 3);
      if (mode == 3) begin
        if1.tx_data  = 8'($urandom);
        if1.tx_start = 1'b1;
        idleCycles(250);
        if1.tx_start = 1'b0;
      end else begin
        applyStimulus(1'b1, 8'($urandom));
        if (mode == 1) begin
          idleCycles($urandom_range(1, 95));
          applyStimulus(1'b1, 8'($urandom));
        end else if (mode == 2) begin
          idleCycles($urandom_range(1, 95));
          rst_n = 1'b0;
          stepCycle();
          rst_n = 1'b1;
        end
      end
      guard = 0;
      while (if1.tx_busy === 1'b1 && guard < 200) begin
        stepCycle();
        guard++;
      end
      checkOutput("rand_frame_end", 32'(guard < 200), 32'd1);
    end

    // Real-rate instance, two stop bits, 0x41.
    if2.tx_start = 1'b1;
    if2.tx_data  = 8'h41;
    stepCycle();
    if2.tx_start = 1'b0;
    busy_cnt = 0;
    edges    = 0;
    idx      = 0;
    prev_txd = if2.txd;
    while (if2.tx_busy === 1'b1 && busy_cnt < 70000) begin
      busy_cnt++;
      stepCycle();
      idx++;
      if (if2.txd !== prev_txd) begin
        edges++;
        checkOutput("long_bit_edge", 32'(idx % 5625), 32'd0);
        prev_txd = if2.txd;
      end
    end
    checkOutput("long_frame_len", 32'(busy_cnt), 32'd61875);
    checkOutput("long_edges",     32'(edges),    32'd5);
    checkOutput("long_done_end",  32'(if2.tx_done), 32'd1);
    idleCycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
